if_fetch_stage: RTL

- Instruction-fetch stage directly downstream of the program counter.
- Takes the current fetch address and its sequential successor from the PC, and issues one request at a time to an instruction memory port using a valid/ready handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Throttles the PC through pc_stall. Supports flush on redirect, discarding stale in-flight data.

---
 rtl/if_fetch_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, DEPTH-entry output FIFO.
// Optional misaligned-fetch trapping under IF_MISALIGN_CHK_EN.
module if_fetch_stage #(
  parameter int unsigned DEPTH = 2
`ifdef IF_MISALIGN_CHK_EN
  ,
  parameter logic [31:0] RST_PC_NOP = 32'h00000013
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic [31:0] pc_ret,
  output logic        pc_stall,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        id_fault
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
`ifdef IF_MISALIGN_CHK_EN
    logic        fault;
`endif
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   pend_pc_q, pend_pc4_q;
  entry_t        fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          slot_free;
  logic          req_hs;
  logic          fault_push;
  logic          push, pop;
  entry_t        push_e;
  entry_t        head;

  assign slot_free = cnt_q < DEPTH_C;
  assign req_hs    = mem_req_valid && mem_req_ready;
  assign pc_stall  = !(req_hs || fault_push);
  assign pop       = id_valid && id_ready;
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: if (req_hs) state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rsp_valid) state_d = S_REQ;
        else if (flush)    state_d = S_DROP;
      end
      S_DROP: if (mem_rsp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  // rst gates the request so nothing is offered while held in reset
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = rst ? pc_addr : '0;
    fault_push    = 1'b0;
    push          = 1'b0;
    push_e        = '0;
    unique case (state_q)
      S_REQ: begin
`ifdef IF_MISALIGN_CHK_EN
        if (pc_addr[1:0] != 2'b00) begin
          fault_push   = rst && slot_free && !flush;
          push_e.instr = RST_PC_NOP;
          push_e.pc    = pc_addr;
          push_e.pc4   = pc_ret;
          push_e.fault = 1'b1;
        end else begin
          mem_req_valid = rst && slot_free && !flush;
        end
`else
        mem_req_valid = rst && slot_free && !flush;
`endif
      end
      S_WAIT: begin
        if (mem_rsp_valid && !flush) begin
          push         = 1'b1;
          push_e.instr = mem_rsp_data;
          push_e.pc    = pend_pc_q;
          push_e.pc4   = pend_pc4_q;
        end
      end
      default: ;
    endcase
    push = push || fault_push;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_pc_q  <= '0;
      pend_pc4_q <= '0;
    end else if (req_hs) begin
      pend_pc_q  <= pc_addr;
      pend_pc4_q <= pc_ret;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_e;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign head     = fifo_q[rd_ptr_q];
  assign id_valid = cnt_q != '0;
  assign id_instr = id_valid ? head.instr : '0;
  assign id_pc    = id_valid ? head.pc : '0;
  assign id_pc4   = id_valid ? head.pc4 : '0;
`ifdef IF_MISALIGN_CHK_EN
  assign id_fault = id_valid && head.fault;
`endif

endmodule
